reg_file_16: RTL and testbench
==============================

// Module: reg_file_16
// PURPOSE
//  16-entry x BITS general-purpose register file for the crp16 datapath.
//  Two combinational read ports, each a 16:1 mux tree; one synchronous write port.
//  Includes a debug dump engine: a counter/FSM that streams all 16 registers out
//  over a valid/ready handshake to a debug/trace consumer.
// PARAMETERS
//  BITS  16  width of each register and of all data ports
// PORTS
//  clock       in   1     rising-edge clock
//  resetn      in   1     asynchronous, active-low reset
//  wr_en       in   1     write enable, sampled on rising clock
//  wr_addr     in   4     write register index
//  wr_data     in   BITS  write data
//  rd_addr_a   in   4     read port A index
//  rd_data_a   out  BITS  read port A data, combinational
//  rd_addr_b   in   4     read port B index
//  rd_data_b   out  BITS  read port B data, combinational
//  dump_start  in   1     request a full-file dump; honoured only in IDLE
//  dump_busy   out  1     high in SEND and DONE
//  dump_valid  out  1     dump beat valid
//  dump_ready  in   1     consumer accepts beat when valid && ready
//  dump_addr   out  4     index of current beat
//  dump_data   out  BITS  register contents for current beat, registered
//  dump_done   out  1     one-cycle pulse after beat 15 accepted
// BEHAVIOUR
//  - Reset (resetn=0, async): all 16 regs=0; FSM=IDLE; dump ptr=0;
//    dump_valid=0, dump_busy=0, dump_done=0, dump_addr=0, dump_data=0.
//  - Write: on posedge clock with wr_en=1, reg[wr_addr] <= wr_data. All 16 writable.
//  - Read: rd_data_x = reg[rd_addr_x], zero-latency combinational; A and B independent.
//  - Read during write to same index: see CONFIGURATION.
//  - FSM states: IDLE, SEND, DONE.
//    IDLE: dump_start=1 -> SEND; ptr<=0; dump_data<=reg[0]; dump_addr<=0.
//    SEND: dump_valid=1. If dump_ready=0, hold dump_addr/dump_data stable.
//      On accept with ptr<15: ptr<=ptr+1; dump_data<=reg[ptr+1]; stay in SEND.
//      On accept with ptr=15: -> DONE; dump_valid falls next cycle.
//    DONE: dump_done=1 for exactly one cycle; -> IDLE.
//  - dump_start while not IDLE: ignored; no restart, no queueing.
//  - dump_data loads the array value present before the same-edge write; a write to
//    the current beat's index while stalled does not change dump_data.
//  - Ptr is 4 bits; the 15->0 wrap never happens in SEND (exit to DONE instead).
//  - Normal writes are never blocked by a dump; dump is a snapshot per beat, not atomic.
//  - resetn asserted mid-dump: immediate return to IDLE with reset values;
//    no dump_done pulse.
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined:
//    write-through forwarding. If wr_en=1 and wr_addr==rd_addr_x, then
//    rd_data_x=wr_data in that same cycle, per port.
//  REG_FILE_BYPASS_EN undefined:
//    rd_data_x returns the old register value until the clock edge.
//  The dump path never bypasses in either configuration.
// TESTING
//  1 Reset: drop resetn mid-cycle -> all rd_data=0, dump_valid=0, dump_busy=0 asynchronously.
//  2 Write/read: write reg[i]=16'h1000+i for i=0..15, then sweep rd_addr_a=i and
//    rd_addr_b=15-i -> both ports match.
//  3 Same-cycle hazard: reg5=16'h0005; wr_en=1, wr_addr=5, wr_data=16'hBEEF, rd_addr_a=5
//    -> bypass build shows rd_data_a=BEEF that cycle; no-bypass build shows 0005, then BEEF.
//  4 Dump with backpressure: dump_ready toggles 1,0,0,1,...
//    -> 16 beats, addr 0..15, data=1000+addr, held while stalled,
//    dump_done one cycle after beat 15, then IDLE.
//  5 Dump interaction: write reg3=16'hCAFE while beat 3 is stalled -> beat 3 data stays
//    1003; a second dump shows CAFE. dump_start during SEND is ignored (exactly 16 beats).
//  6 Reset mid-dump: assert resetn at beat 7 -> dump_valid=0 immediately;
//    no dump_done pulse; a new dump_start begins at addr 0.

Source files
------------

// File: rtl/reg_file_16.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : reg_file_16                                                 |
// | Purpose  : 16-entry x BITS general-purpose register file for the crp16 |
// |            datapath. Two independent combinational read ports, one     |
// |            synchronous write port, and a debug dump engine that        |
// |            streams all 16 registers over a valid/ready handshake.      |
// | Options  : REG_FILE_BYPASS_EN - when defined, a same-cycle write to    |
// |            the index being read is forwarded to that read port. The    |
// |            dump path never forwards.                                   |
// | Ports    : clock, resetn (async, active low)                           |
// |            wr_en, wr_addr[3:0], wr_data[BITS-1:0]     write port       |
// |            rd_addr_a/b[3:0] -> rd_data_a/b[BITS-1:0]  read ports       |
// |            dump_start, dump_ready                     dump control in  |
// |            dump_busy, dump_valid, dump_addr[3:0],                      |
// |            dump_data[BITS-1:0], dump_done             dump stream out  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module reg_file_16 #(
   parameter int BITS = 16
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            wr_en,
   input  logic [3:0]      wr_addr,
   input  logic [BITS-1:0] wr_data,
   input  logic [3:0]      rd_addr_a,
   output logic [BITS-1:0] rd_data_a,
   input  logic [3:0]      rd_addr_b,
   output logic [BITS-1:0] rd_data_b,
   input  logic            dump_start,
   output logic            dump_busy,
   output logic            dump_valid,
   input  logic            dump_ready,
   output logic [3:0]      dump_addr,
   output logic [BITS-1:0] dump_data,
   output logic            dump_done
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_send = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   logic [BITS-1:0] r_mem [16];
   logic [1:0]      r_state;
   logic [3:0]      r_ptr;
   logic [BITS-1:0] r_dump_data;
   logic [3:0]      w_ptr_next;
   logic            w_accept;

   // ---------------------------------------------------------------------
   // Storage: one register per entry, each with its own address decode.
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_regs
         localparam logic [3:0] c_idx = 4'(gi);
         always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
               r_mem[gi] <= '0;
            end else if (wr_en && (wr_addr == c_idx)) begin
               r_mem[gi] <= wr_data;
            end
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------
`ifdef REG_FILE_BYPASS_EN
   // Write-through: the value being written this cycle is visible now.
   assign rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : r_mem[rd_addr_a];
   assign rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : r_mem[rd_addr_b];
`else
   // Old value is returned until the write edge.
   assign rd_data_a = r_mem[rd_addr_a];
   assign rd_data_b = r_mem[rd_addr_b];
`endif

   // ---------------------------------------------------------------------
   // Dump engine
   // ---------------------------------------------------------------------
   assign w_accept   = (r_state == c_send) && dump_ready;
   assign w_ptr_next = r_ptr + 4'd1;

   // dump_data samples r_mem with non-blocking semantics, so it always
   // captures the array contents from before any write on the same edge.
   // While a beat is stalled dump_data is not reloaded, so writes to the
   // current beat's index cannot disturb it.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= c_idle;
         r_ptr       <= 4'd0;
         r_dump_data <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (dump_start) begin
                  r_state     <= c_send;
                  r_ptr       <= 4'd0;
                  r_dump_data <= r_mem[0];
               end
            end
            c_send: begin
               if (w_accept) begin
                  // Last beat exits to DONE, so the pointer never wraps here.
                  if (r_ptr == 4'd15) begin
                     r_state <= c_done;
                  end else begin
                     r_ptr       <= w_ptr_next;
                     r_dump_data <= r_mem[w_ptr_next];
                  end
               end
            end
            c_done: begin
               r_state <= c_idle;
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

   assign dump_valid = (r_state == c_send);
   assign dump_busy  = (r_state == c_send) || (r_state == c_done);
   assign dump_done  = (r_state == c_done);
   assign dump_addr  = r_ptr;
   assign dump_data  = r_dump_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_16.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_reg_file_16                                              |
// | Purpose  : Directed self-checking bench for reg_file_16: reset, write/ |
// |            read sweep, same-cycle hazard, dump with backpressure,      |
// |            dump/write interaction and reset in the middle of a dump.   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_reg_file_16;

   logic        clk;
   logic        resetn;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic [3:0]  rd_addr_a;
   logic [15:0] rd_data_a;
   logic [3:0]  rd_addr_b;
   logic [15:0] rd_data_b;
   logic        dump_start;
   logic        dump_busy;
   logic        dump_valid;
   logic        dump_ready;
   logic [3:0]  dump_addr;
   logic [15:0] dump_data;
   logic        dump_done;

   int          n_tests;
   int          n_fail;
   logic [15:0] mdl [16];

   reg_file_16 #(.BITS(16)) dut (
      .clock      (clk),
      .resetn     (resetn),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr_a  (rd_addr_a),
      .rd_data_a  (rd_data_a),
      .rd_addr_b  (rd_addr_b),
      .rd_data_b  (rd_data_b),
      .dump_start (dump_start),
      .dump_busy  (dump_busy),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_done  (dump_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      mdl[a]  = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Runs one dump with dump_ready pattern 1,0,0 repeating. Optionally
   // writes CAFE to reg3 while beat wr_beat is stalled, and optionally
   // asserts reset when beat rst_beat is first presented. A dump_start
   // pulse is issued during beat 8 and must be ignored.
   task automatic run_dump(input int wr_beat, input int rst_beat, input string nm);
      int          beat;
      int          cyc;
      int          k;
      bit          fin;
      bit          wrote;
      logic [15:0] cur;
      beat = 0; cyc = 0; k = 0; fin = 0; wrote = 0;
      @(negedge clk);
      dump_start = 1'b1;
      dump_ready = 1'b0;
      @(negedge clk);
      dump_start = 1'b0;
      check({nm, " busy"}, {31'b0, dump_busy}, 32'd1);
      cur = mdl[0];
      while (!fin && cyc < 400) begin
         check({nm, " valid"}, {31'b0, dump_valid}, 32'd1);
         check({nm, " addr"}, {28'b0, dump_addr}, beat);
         check({nm, " data"}, {16'b0, dump_data}, {16'b0, cur});
         if (beat == rst_beat) begin
            resetn = 1'b0;
            #1;
            check({nm, " rst valid"}, {31'b0, dump_valid}, 32'd0);
            check({nm, " rst busy"}, {31'b0, dump_busy}, 32'd0);
            check({nm, " rst addr"}, {28'b0, dump_addr}, 32'd0);
            check({nm, " rst data"}, {16'b0, dump_data}, 32'd0);
            for (int i = 0; i < 16; i++) mdl[i] = '0;
            wr_en = 1'b0; dump_ready = 1'b0; dump_start = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            repeat (3) begin
               @(negedge clk);
               check({nm, " rst no done"}, {31'b0, dump_done}, 32'd0);
               check({nm, " rst no valid"}, {31'b0, dump_valid}, 32'd0);
            end
            return;
         end
         dump_ready = (k % 3 == 0);
         k++;
         dump_start = (beat == 8);
         if (beat == wr_beat && !dump_ready && !wrote) begin
            wr_en   = 1'b1;
            wr_addr = 4'd3;
            wr_data = 16'hCAFE;
            mdl[3]  = 16'hCAFE;
            wrote   = 1'b1;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (dump_ready) begin
            beat++;
            if (beat == 16) fin = 1'b1;
            else cur = mdl[beat];
         end
      end
      dump_ready = 1'b0;
      dump_start = 1'b0;
      wr_en      = 1'b0;
      if (!fin) begin
         check({nm, " timeout"}, 32'd0, 32'd1);
      end else begin
         check({nm, " done pulse"}, {31'b0, dump_done}, 32'd1);
         check({nm, " done valid"}, {31'b0, dump_valid}, 32'd0);
         check({nm, " done busy"}, {31'b0, dump_busy}, 32'd1);
         @(negedge clk);
         check({nm, " done end"}, {31'b0, dump_done}, 32'd0);
         check({nm, " idle busy"}, {31'b0, dump_busy}, 32'd0);
         check({nm, " idle valid"}, {31'b0, dump_valid}, 32'd0);
         @(negedge clk);
         check({nm, " no restart"}, {31'b0, dump_valid}, 32'd0);
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_a = '0; rd_addr_b = '0; dump_start = 1'b0; dump_ready = 1'b0;
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // 1: asynchronous reset mid-cycle clears contents and dump outputs
      write_reg(4'd9, 16'hABCD);
      rd_addr_a = 4'd9; rd_addr_b = 4'd9;
      #1;
      check("pre-reset rd_a", {16'b0, rd_data_a}, 32'h0000ABCD);
      #2;
      resetn = 1'b0;
      #1;
      check("reset rd_a", {16'b0, rd_data_a}, 32'd0);
      check("reset rd_b", {16'b0, rd_data_b}, 32'd0);
      check("reset valid", {31'b0, dump_valid}, 32'd0);
      check("reset busy", {31'b0, dump_busy}, 32'd0);
      check("reset done", {31'b0, dump_done}, 32'd0);
      check("reset addr", {28'b0, dump_addr}, 32'd0);
      check("reset data", {16'b0, dump_data}, 32'd0);
      mdl[9] = '0;
      @(negedge clk);
      resetn = 1'b1;

      // 2: write every register, sweep both ports in opposite directions
      for (int i = 0; i < 16; i++) write_reg(4'(i), 16'h1000 + 16'(i));
      for (int i = 0; i < 16; i++) begin
         rd_addr_a = 4'(i);
         rd_addr_b = 4'(15 - i);
         #1;
         check("sweep rd_a", {16'b0, rd_data_a}, 32'h1000 + i);
         check("sweep rd_b", {16'b0, rd_data_b}, 32'h1000 + 15 - i);
      end

      // 3: read during write to the same index
      write_reg(4'd5, 16'h0005);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
      rd_addr_a = 4'd5; rd_addr_b = 4'd6;
      #1;
`ifdef REG_FILE_BYPASS_EN
      check("hazard rd_a", {16'b0, rd_data_a}, 32'h0000BEEF);
`else
      check("hazard rd_a", {16'b0, rd_data_a}, 32'h00000005);
`endif
      check("hazard rd_b", {16'b0, rd_data_b}, 32'h00001006);
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      check("hazard after", {16'b0, rd_data_a}, 32'h0000BEEF);
      write_reg(4'd5, 16'h1005);

      // 4: dump with backpressure
      run_dump(-1, -1, "dump4");

      // 5: write reg3 while beat 3 stalled; readback then shows CAFE
      run_dump(3, -1, "dump5");
      rd_addr_a = 4'd3;
      #1;
      check("reg3 readback", {16'b0, rd_data_a}, 32'h0000CAFE);

      // 6: second dump shows CAFE at beat 3, reset at beat 7, then fresh dump
      run_dump(-1, 7, "dump6a");
      run_dump(-1, -1, "dump6b");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
